// File: rtl/counter_load_ctrl.sv
// Initiator for the counter's two-step load handshake, with pad output-enable
// turnaround, timeout abort and an optional capture readback check (COUNTER_LOAD_VERIFY_EN).
module counter_load_ctrl #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_req_valid,
  input  logic [WIDTH-1:0] in_req_value,
  output logic             out_req_ready,
  input  logic [WIDTH-1:0] in_ena,
  input  logic [WIDTH-1:0] in_counter_value,
  output logic             out_load_now,
  output logic [WIDTH-1:0] out_load_value,
  output logic             out_oe,
  output logic             out_busy,
  output logic             out_done,
  output logic             out_err,
  output logic [1:0]       out_err_code
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] value_q;
  logic [TW-1:0]    tcount;
  logic             ena_zero;
  logic             ena_ones;
  logic             timeout;
  logic             mismatch;

  assign ena_zero = (in_ena == '0);
  assign ena_ones = (in_ena == '1);
  assign timeout  = (tcount == TW'(TIMEOUT_CYCLES - 1));

`ifdef COUNTER_LOAD_VERIFY_EN
  assign mismatch = (in_counter_value != value_q);
`else
  logic unused_counter_value;
  assign unused_counter_value = ^in_counter_value;
  assign mismatch = 1'b0;
`endif

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state        <= IDLE;
      value_q      <= '0;
      tcount       <= '0;
      out_done     <= 1'b0;
      out_err      <= 1'b0;
      out_err_code <= 2'b00;
    end else begin
      out_done <= 1'b0;
      out_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_req_valid) begin
            value_q      <= in_req_value;
            out_err_code <= 2'b00;
            tcount       <= '0;
            state        <= ARM;
          end
        end
        ARM: begin
          if (timeout) begin
            state        <= IDLE;
            out_err      <= 1'b1;
            out_err_code <= 2'b01;
          end else begin
            tcount <= tcount + 1'b1;
            if (ena_zero) state <= DRIVE;
          end
        end
        DRIVE: begin
          // Completion is checked first so it wins over a coincident timeout.
          if (ena_ones) begin
            state    <= IDLE;
            out_done <= 1'b1;
            if (mismatch) begin
              out_err      <= 1'b1;
              out_err_code <= 2'b10;
            end
          end else if (timeout) begin
            state        <= IDLE;
            out_err      <= 1'b1;
            out_err_code <= 2'b01;
          end else begin
            tcount <= tcount + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // load_now drops in the cycle the enable returns high so the counter resumes counting.
  always_comb begin
    out_load_now   = 1'b0;
    out_load_value = '0;
    out_oe         = 1'b0;
    case (state)
      ARM: begin
        out_load_now   = 1'b1;
        out_load_value = value_q;
        out_oe         = ena_zero;
      end
      DRIVE: begin
        out_load_now   = !ena_ones;
        out_load_value = value_q;
        out_oe         = ena_zero;
      end
      default: ;
    endcase
  end

  assign out_req_ready = (state == IDLE);
  assign out_busy      = (state != IDLE);

endmodule

// File: tb/tb_counter_load_ctrl.sv
// Scoreboard bench for counter_load_ctrl: a behavioural counter drives the enable
// handshake, and each request's outcome is predicted from the handshake rules.
module tb_counter_load_ctrl;
  localparam int WIDTH = 8;
  localparam int TO    = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic [WIDTH-1:0] req_value;
  logic             req_ready;
  logic [WIDTH-1:0] ena = 8'hFF;
  logic [WIDTH-1:0] cnt = 8'h00;
  logic             load_now;
  logic [WIDTH-1:0] load_value;
  logic             oe;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       err_code;

  logic env_stale   = 1'b0;
  logic env_stuck   = 1'b0;
  logic env_corrupt = 1'b0;

  counter_load_ctrl #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TO)) dut (
    .in_clk          (clk),
    .in_rst          (rst),
    .in_req_valid    (req_valid),
    .in_req_value    (req_value),
    .out_req_ready   (req_ready),
    .in_ena          (ena),
    .in_counter_value(cnt),
    .out_load_now    (load_now),
    .out_load_value  (load_value),
    .out_oe          (oe),
    .out_busy        (busy),
    .out_done        (done),
    .out_err         (err),
    .out_err_code    (err_code)
  );

  always #5 clk = ~clk;

  // Behavioural counter: releases pins on load_now, captures on the next load_now, then counts.
  always @(posedge clk) begin
    if (rst)                          ena <= 8'hFF;
    else if (env_stale)               ena <= 8'h00;
    else if (env_stuck) begin         ena <= 8'hFF; cnt <= cnt + 8'd1; end
    else if (ena == 8'hFF && load_now) ena <= 8'h00;
    else if (ena == 8'h00 && load_now) begin
      cnt <= env_corrupt ? load_value - 8'd1 : load_value;
      ena <= 8'hFF;
    end
    else if (ena == 8'hFF)            cnt <= cnt + 8'd1;
  end

  typedef struct {
    logic       done;
    logic       err;
    logic [1:0] code;
    int         lat;
    int         ln;
    int         oe;
    logic       chk_cnt;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc = 0, acc_cyc = 0, ln_c = 0, oe_c = 0;

  task automatic chk(string name, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Modes: 0 nominal, 1 stale enable, 2 stuck counter, 3 corrupted capture.
  function automatic exp_t predict(logic [7:0] v, int mode);
    exp_t e;
    e.done = 1'b1; e.err = 1'b0; e.code = 2'b00;
    e.lat = 4; e.ln = 2; e.oe = 1; e.chk_cnt = 1'b1; e.cnt = v + 8'd1;
    case (mode)
      1: begin e.lat = 3; e.ln = 1; end
      2: begin
        e.done = 1'b0; e.err = 1'b1; e.code = 2'b01;
        e.lat = TO + 1; e.ln = TO; e.oe = 0; e.chk_cnt = 1'b0;
      end
      3: begin
        e.cnt = v;
`ifdef COUNTER_LOAD_VERIFY_EN
        e.err = 1'b1; e.code = 2'b10;
`endif
      end
      default: ;
    endcase
    return e;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && req_valid && req_ready) begin
      acc_cyc <= cyc;
      ln_c    <= 0;
      oe_c    <= 0;
    end else begin
      ln_c <= ln_c + int'(load_now);
      oe_c <= oe_c + int'(oe);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_vs_busy", req_ready, !busy);
      if (oe) chk("oe_only_when_released", ena, 8'h00);
      if (!busy) chk("idle_load_value", load_value, 0);
      if (done || err) begin
        if (sb.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_pulse: done=%0b err=%0b, nothing outstanding", done, err);
        end else begin
          mon_e = sb.pop_front();
          chk("done", done, mon_e.done);
          chk("err", err, mon_e.err);
          chk("err_code", err_code, mon_e.code);
          chk("latency", cyc - acc_cyc, mon_e.lat);
          chk("load_now_cycles", ln_c, mon_e.ln);
          chk("oe_cycles", oe_c, mon_e.oe);
          if (mon_e.chk_cnt) chk("counter_value", cnt, mon_e.cnt);
        end
      end
    end
  end

  task automatic wait_accept();
    int n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) begin
      n_vec++; n_fail++;
      $display("FAIL accept_timeout: ready stayed 0, expected 1");
    end
    @(posedge clk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      n_vec++; n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_req(logic [7:0] v, int mode);
    sb.push_back(predict(v, mode));
    env_stuck   = (mode == 2);
    env_corrupt = (mode == 3);
    if (mode == 1) begin
      env_stale = 1'b1;
      @(negedge clk);
      env_stale = 1'b0;
    end
    req_valid = 1'b1;
    req_value = v;
    wait_accept();
    @(negedge clk);
    req_valid = 1'b0;
    req_value = 8'($urandom);
    wait_drain();
    env_stuck   = 1'b0;
    env_corrupt = 1'b0;
    if (mode == 2) begin
      repeat (2) @(negedge clk);
      chk("err_code_held", err_code, 2'b01);
      chk("load_now_after_timeout", load_now, 0);
      chk("oe_after_timeout", oe, 0);
      chk("ready_after_timeout", req_ready, 1);
    end
  endtask

  task automatic do_b2b(logic [7:0] v1, logic [7:0] v2);
    sb.push_back(predict(v1, 0));
    sb.push_back(predict(v2, 0));
    req_valid = 1'b1;
    req_value = v1;
    wait_accept();
    @(negedge clk);
    req_value = v2;
    chk("ready_low_while_busy", req_ready, 0);
    wait_accept();
    @(negedge clk);
    req_valid = 1'b0;
    wait_drain();
  endtask

  task automatic do_reset_mid(logic [7:0] v);
    req_valid = 1'b1;
    req_value = v;
    wait_accept();
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_in_drive", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_load_now", load_now, 0);
    chk("rst_mid_oe", oe, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_err", err, 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_value = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_ready", req_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_load_now", load_now, 0);
    chk("reset_oe", oe, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_err_code", err_code, 0);
    chk("reset_load_value", load_value, 0);
    rst = 1'b0;
    @(negedge clk);

    do_req(8'h5A, 0);
    do_b2b(8'h10, 8'hF0);
    do_req(8'($urandom), 2);
    do_req(8'($urandom), 1);
    do_req(8'h34, 3);
    do_reset_mid(8'h77);
    do_req(8'h00, 0);
    do_req(8'hFF, 3);

    for (int i = 0; i < 30; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (i % 5 == 4)  do_b2b(8'($urandom), 8'($urandom));
      else if (sel < 6) do_req(8'($urandom), 0);
      else if (sel < 8) do_req(8'($urandom), 1);
      else if (sel < 9) do_req(8'($urandom), 3);
      else              do_req(8'($urandom), 2);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/counter_load_ctrl.md
Name: counter_load_ctrl

Overview:
- Initiator side of the counter load handshake: takes a value from an upstream request interface, drives the counter's load-now and load-value inputs, and sequences the two-step enable handshake.
- Step one is the counter releasing the shared value pins (enable goes 8'h00). Step two is the counter capturing the value (enable returns to 8'hFF).
- Adds bus-turnaround control (pad output enable), timeout detection and an optional capture readback check.
- Sits between control logic and the counter.

Parameters:
- WIDTH, 8, width of load value, counter value and enable bus.
- TIMEOUT_CYCLES, 16, maximum cycles spent in ARM+DRIVE before abort (>=3).

Ports:
- in_clk  input  1  clock, all state on rising edge
- in_rst  input  1  synchronous, active-high reset
- in_req_valid  input  1  upstream has a value to load
- in_req_value  input  WIDTH  value to load
- out_req_ready  output  1  high in IDLE; request accepted when valid&ready
- in_ena  input  WIDTH  counter's enable output (8'hFF = counter owns pins/idle, 8'h00 = released)
- in_counter_value  input  WIDTH  counter's current value
- out_load_now  output  1  to counter load-now input
- out_load_value  output  WIDTH  to counter load-value input
- out_oe  output  1  pad output enable for out_load_value
- out_busy  output  1  state != IDLE
- out_done  output  1  one-cycle pulse, load completed
- out_err  output  1  one-cycle pulse, load aborted/failed
- out_err_code  output  2  01 timeout, 10 verify mismatch; held until next accepted request

Behaviour:
- Reset (in_rst high at an edge): state IDLE, value register 0, timeout count 0, out_done/out_err 0, out_err_code 00. Combinational outputs follow: out_load_now 0, out_oe 0, out_req_ready 1, out_busy 0. Reset mid-operation aborts with no done/err pulse.
- IDLE: out_load_value = 0. On valid&ready, latch in_req_value, clear out_err_code and timeout count, go to ARM.
- ARM: out_load_now = 1. out_load_value = latched value, held constant through ARM and DRIVE. out_oe = (in_ena == 8'h00), combinational.
- ARM transition: when in_ena == 8'h00 (the counter captures in this same cycle), go to DRIVE.
- DRIVE: out_load_now = (in_ena != 8'hFF), combinational. It must be low in the cycle the enable returns to 8'hFF, so the counter does not re-arm and resumes counting next edge. out_oe = (in_ena == 8'h00).
- DRIVE transition: when in_ena == 8'hFF, go to IDLE and pulse out_done next cycle.
- Enable values other than 8'h00/8'hFF are treated as "not yet" in both states.
- Nominal latency: request accept at edge E1, counter captures at E3, out_done high in cycle after E4. The counter is expected to reach 8'h00 at E2.
- Timeout: the count increments every cycle in ARM/DRIVE. When it reaches TIMEOUT_CYCLES-1 without completing, go to IDLE, pulse out_err, set out_err_code = 01, drive out_load_now and out_oe low.
- Completion beats timeout: if completion and timeout occur in the same cycle, completion wins.
- out_req_ready is low whenever busy. A request asserted while busy is held upstream, not dropped.
- in_ena already 8'h00 on entry to ARM (stale counter state) is legal; proceed to DRIVE immediately.
- out_oe and the counter's enable are never simultaneously driving. out_oe is 0 in IDLE regardless of in_ena.

Optional Feature:
- Macro: COUNTER_LOAD_VERIFY_EN.
- With the macro: in the DRIVE cycle where in_ena == 8'hFF, compare in_counter_value to the latched value. On mismatch, pulse out_err alongside out_done and set out_err_code = 10.
- Without the macro: no comparison is made; in_counter_value is unused; code 10 is never produced.

Test Plan:
- Nominal: reset, request 8'h5A against a behavioural counter model. Required: load_now high for exactly 2 cycles; oe high 1 cycle; counter reads 8'h5A then 8'h5B; out_done pulses once at E4+; no err.
- Back-to-back: hold valid with 8'h10 then 8'hF0. Required: second request accepted only after done; counter captures each value; ready low while busy.
- Stuck counter: in_ena held 8'hFF forever. Required: out_err pulse after 16 cycles; code 01; load_now/oe low; ready high.
- Reset mid-operation: assert in_rst in DRIVE. Required: next cycle IDLE, load_now 0, oe 0, no done/err pulse.
- Stale enable: in_ena = 8'h00 at accept. Required: ARM for 1 cycle, oe high immediately, completes when model returns 8'hFF.
- Verify (macro on): model captures 8'h33 instead of 8'h34. Required: out_done and out_err together, code 10. Macro off: same stimulus gives done only, code 00.
